// File: rtl/div_pkg.sv
// Shared constants for the sequential 16/8 restoring divider.
// State codes, datapath widths and the divide-by-zero result constant.
package div_pkg;

    localparam int N_WIDTH = 16;
    localparam int D_WIDTH = 8;
    localparam int CNT_W   = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [N_WIDTH-1:0] QUO_DZ   = 16'hFFFF;
    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(N_WIDTH - 1);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
import div_pkg::*;

module div_step (
    input  logic [D_WIDTH:0]   i_r,
    input  logic               i_q_msb,
    input  logic [D_WIDTH-1:0] i_d,
    output logic [D_WIDTH:0]   o_r,
    output logic               o_bit
);

    logic [D_WIDTH+1:0] w_rs;
    logic               w_ge;

    // The extra top bit keeps the compare exact; R itself never exceeds 9 bits.
    assign w_rs  = {i_r, i_q_msb};
    assign w_ge  = (w_rs >= {2'b00, i_d});
    assign o_r   = w_ge ? (w_rs[D_WIDTH:0] - {1'b0, i_d}) : w_rs[D_WIDTH:0];
    assign o_bit = w_ge;

endmodule

// File: rtl/seq_divider_16x8.sv
// Sequential radix-2 restoring divider, 16-bit dividend / 8-bit divisor, one quotient bit per clock.
// Optional DIV_ZERO_FAST_EN: a zero divisor finishes in 1 cycle without entering CALC.
import div_pkg::*;

module seq_divider_16x8 (
    input  logic               clk,
    input  logic               reset_a,
    input  logic               start,
    input  logic [N_WIDTH-1:0] dividend,
    input  logic [D_WIDTH-1:0] divisor,
    output logic               busy,
    output logic               done_flag,
    output logic [N_WIDTH-1:0] quotient,
    output logic [D_WIDTH-1:0] remainder,
    output logic               div_by_zero
);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_WIDTH-1:0] r_q;
    logic [D_WIDTH-1:0] r_d;
    logic [D_WIDTH:0]   r_r;
    logic [N_WIDTH-1:0] r_quo;
    logic [D_WIDTH-1:0] r_rem;
    logic               r_dz;
    logic               r_done;
`ifdef DIV_ZERO_FAST_EN
    logic               r_fast;
`endif

    logic [D_WIDTH:0]   w_r_next;
    logic               w_bit;
    logic [N_WIDTH-1:0] w_q_next;

    div_step u_step (
        .i_r     (r_r),
        .i_q_msb (r_q[N_WIDTH-1]),
        .i_d     (r_d),
        .o_r     (w_r_next),
        .o_bit   (w_bit)
    );

    assign w_q_next = {r_q[N_WIDTH-2:0], w_bit};

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_r     <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dz    <= 1'b0;
            r_done  <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
            r_fast  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_q   <= dividend;
                        r_d   <= divisor;
                        r_r   <= '0;
                        r_cnt <= CNT_INIT;
`ifdef DIV_ZERO_FAST_EN
                        if (divisor == '0) begin
                            r_state <= DONE;
                            r_fast  <= 1'b1;
                        end else begin
                            r_state <= CALC;
                        end
`else
                        r_state <= CALC;
`endif
                    end
                end
                CALC: begin
                    r_r   <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_quo   <= w_q_next;
                        r_rem   <= w_r_next[D_WIDTH-1:0];
                        r_dz    <= (r_d == '0);
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
`ifdef DIV_ZERO_FAST_EN
                    // Fast zero-divisor path publishes its result one edge after accept.
                    if (r_fast) begin
                        r_quo  <= QUO_DZ;
                        r_rem  <= r_q[D_WIDTH-1:0];
                        r_dz   <= 1'b1;
                        r_done <= 1'b1;
                        r_fast <= 1'b0;
                    end else begin
                        r_done  <= 1'b0;
                        r_state <= IDLE;
                    end
`else
                    r_done  <= 1'b0;
                    r_state <= IDLE;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = (r_state == CALC);
    assign done_flag   = r_done;
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dz;

endmodule

// File: tb/tb_seq_divider_16x8.sv
// Self-checking bench for seq_divider_16x8: cycle-level behavioural model plus directed literal cases.
// Honours DIV_ZERO_FAST_EN for the zero-divisor latency.
module tb_seq_divider_16x8;

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST   = 1'b1;
    localparam int DZ_LAT = 1;
`else
    localparam bit FAST   = 1'b0;
    localparam int DZ_LAT = 16;
`endif

    logic        clk = 1'b0;
    logic        reset_a = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        busy, done_flag, div_by_zero;
    logic [15:0] quotient;
    logic [7:0]  remainder;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_divider_16x8 dut (
        .clk         (clk),
        .reset_a     (reset_a),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done_flag   (done_flag),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_q(input logic [15:0] dd, input logic [7:0] dv);
        return (dv == 0) ? 16'hFFFF : dd / {8'd0, dv};
    endfunction

    function automatic logic [7:0] ref_r(input logic [15:0] dd, input logic [7:0] dv);
        logic [15:0] t;
        t = (dv == 0) ? dd : dd % {8'd0, dv};
        return t[7:0];
    endfunction

    // Timing model: phase 0 waiting, 1 dividing (m_left edges to go), 2 result shown, 3 fast zero path.
    int          m_phase, m_left;
    logic [15:0] m_dd;
    logic [7:0]  m_dv;
    logic        e_busy, e_done, e_dz;
    logic [15:0] e_q;
    logic [7:0]  e_r;

    always @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            m_phase <= 0; m_left <= 0; m_dd <= '0; m_dv <= '0;
            e_busy <= 1'b0; e_done <= 1'b0; e_dz <= 1'b0; e_q <= '0; e_r <= '0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_dd <= dividend;
                    m_dv <= divisor;
                    if (FAST && divisor == 0) m_phase <= 3;
                    else begin m_phase <= 1; m_left <= 16; e_busy <= 1'b1; end
                end
                1: if (m_left == 1) begin
                    e_busy <= 1'b0; e_done <= 1'b1; m_phase <= 2;
                    e_q <= ref_q(m_dd, m_dv); e_r <= ref_r(m_dd, m_dv); e_dz <= (m_dv == 0);
                end else m_left <= m_left - 1;
                2: begin e_done <= 1'b0; m_phase <= 0; end
                default: begin
                    e_done <= 1'b1; m_phase <= 2;
                    e_q <= ref_q(m_dd, m_dv); e_r <= ref_r(m_dd, m_dv); e_dz <= 1'b1;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, e_busy);
            chk("done_flag", done_flag, e_done);
            chk("quotient", quotient, e_q);
            chk("remainder", remainder, e_r);
            chk("div_by_zero", div_by_zero, e_dz);
            chk("busy_and_done_exclusive", busy & done_flag, 1'b0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called one step after an edge with the DUT idle; measures edges from accept to done_flag.
    task automatic run_op(input string nm, input logic [15:0] dd, input logic [7:0] dv,
                          input logic [15:0] xq, input logic [7:0] xr, input logic xdz, input int xlat);
        int lat;
        lat = -1;
        start = 1'b1; dividend = dd; divisor = dv;
        tick(1);
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (done_flag) begin lat = i; break; end
        end
        chk({nm, "_latency"}, lat, xlat);
        chk({nm, "_quotient"}, quotient, xq);
        chk({nm, "_remainder"}, remainder, xr);
        chk({nm, "_dz"}, div_by_zero, xdz);
        chk({nm, "_model_q"}, e_q, xq);
        chk({nm, "_model_r"}, e_r, xr);
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int dcnt, gap, ndone;
        logic [15:0] got_q;
        logic [7:0]  got_r;
        #2 reset_a = 1'b1;
        chk_en = 1'b1;
        tick(2);
        chk("reset_quotient", quotient, 16'h0);
        chk("reset_remainder", remainder, 8'h0);
        chk("reset_flags", {busy, done_flag, div_by_zero}, 3'b000);
        reset_a = 1'b0;
        tick(1);

        run_op("t1_1000_7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16);
        run_op("t2_ffff_ff", 16'hFFFF, 8'hFF, 16'd257, 8'd0, 1'b0, 16);
        run_op("t2_5_10", 16'd5, 8'd10, 16'd0, 8'd5, 1'b0, 16);
        run_op("t3_dz", 16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b1, DZ_LAT);
        run_op("dividend0", 16'd0, 8'd13, 16'd0, 8'd0, 1'b0, 16);

        // Start ignored while busy, operands changed later.
        start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
        tick(1);
        start = 1'b0;
        tick(2);
        start = 1'b1; dividend = 16'd50; divisor = 8'd5;
        tick(1);
        start = 1'b0;
        tick(5);
        dividend = 16'hBEEF; divisor = 8'd3;
        dcnt = 0; got_q = '0; got_r = '0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (done_flag) begin dcnt++; got_q = quotient; got_r = remainder; end
        end
        chk("t4_done_pulses", dcnt, 1);
        chk("t4_quotient", got_q, 16'd142);
        chk("t4_remainder", got_r, 8'd6);

        // Reset mid-operation.
        start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
        tick(1);
        start = 1'b0;
        tick(8);
        reset_a = 1'b1;
        #1;
        chk("t5_abort_outputs", {busy, done_flag, div_by_zero, quotient, remainder}, 27'd0);
        tick(1);
        reset_a = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (done_flag) dcnt++;
        end
        chk("t5_no_done_after_abort", dcnt, 0);
        run_op("t5_200_9", 16'd200, 8'd9, 16'd22, 8'd2, 1'b0, 16);

        // Back-to-back with start held high.
        start = 1'b1; dividend = 16'd40000; divisor = 8'd123;
        ndone = 0; gap = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (done_flag) begin
                if (ndone > 0) chk("t6_idle_gap", gap > 0, 1'b1);
                chk("t6_quotient", quotient, 16'd325);
                chk("t6_remainder", remainder, 8'd25);
                ndone++; gap = 0;
            end else if (!busy) gap++;
        end
        start = 1'b0;
        chk("t6_done_count", ndone >= 3, 1'b1);
        tick(3);

        // Randomized traffic, checked cycle by cycle against the model.
        ndone = 0;
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            dividend = $urandom;
            divisor = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            tick(1);
            if (done_flag) ndone++;
        end
        start = 1'b0;
        chk("random_completions_seen", ndone > 50, 1'b1);
        tick(20);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
